// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Also holds the standard 16-bit PC incrementer used for every +2 step.
package fetch_pkg;

  localparam int          INSTR_W = 16;
  localparam logic [15:0] PC_STEP = 16'h0002;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [15:0]        pc;
    logic [15:0]        pc_plus2;
  } skid_entry_t;

  // Standard 16-bit incrementer; wraps modulo 2^16 with no carry out.
  function automatic logic [15:0] inc16(input logic [15:0] a);
    return a + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch bus: req/addr held until a one-cycle ack with rdata.
interface fetch_pc_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_ctrl_skid1.sv
// One-entry skid buffer in front of a registered output slot, with flush.
// The skid always drains into the output before a newer entry may take the slot.
module fetch_skid1
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  skid_entry_t in_data,
  output logic        in_ready,
  output logic        slot_free,
  input  logic        out_ready,
  output logic        out_valid,
  output skid_entry_t out_data
);

  logic        out_valid_r;
  logic        skid_valid_r;
  skid_entry_t out_data_r;
  skid_entry_t skid_data_r;
  logic        slot_free_s;

  // Output slot can take a new entry when it is empty or being consumed.
  always_comb begin
    slot_free_s = ~out_valid_r | out_ready;
  end

  // Output and skid registers; flush drops both entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_data_r   <= '0;
      skid_data_r  <= '0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (slot_free_s) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_data_r   <= skid_data_r;
        skid_valid_r <= in_valid;
        if (in_valid) skid_data_r <= in_data;
      end else begin
        out_valid_r <= in_valid;
        if (in_valid) out_data_r <= in_data;
      end
    end else if (in_valid) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= in_data;
    end
  end

  assign in_ready  = ~skid_valid_r;
  assign slot_free = slot_free_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch front end: owns the PC, issues word fetches, handles redirect/halt,
// and hands {instr, pc, pc+2} to decode through a one-entry skid.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_pc_ctrl_if.master     imem,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  input  logic                halt,
  input  logic                if_ready,
  output logic                if_valid,
  output logic [WIDTH-1:0]    if_instr,
  output logic [WIDTH-1:0]    if_pc,
  output logic [WIDTH-1:0]    if_pc_plus2,
  output logic                halted
);

  state_t      state_r, state_nxt_s;
  logic [15:0] pc_r, pc_nxt_s;
  logic [15:0] addr_r;
  logic        squash_r, squash_nxt_s;
  logic        halt_pend_r, halt_pend_nxt_s;
  logic        ack_s, accept_s, flush_s, hold_addr_s;
  logic        skid_empty_s, slot_free_s;
  skid_entry_t entry_s, out_entry_s;

  // Next-state, next-PC and squash decisions.
  always_comb begin
    ack_s           = imem.imem_ack & (state_r == REQ);
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    squash_nxt_s    = squash_r;
    halt_pend_nxt_s = halt_pend_r;
    accept_s        = 1'b0;
    flush_s         = 1'b0;
    entry_s         = '{instr: imem.imem_rdata, pc: pc_r, pc_plus2: inc16(pc_r)};
    case (state_r)
      IDLE: begin
        if (halt) begin
          state_nxt_s = HALTED;
        end else if (redirect_valid) begin
          flush_s     = 1'b1;
          pc_nxt_s    = redirect_pc & 16'hFFFE;
          state_nxt_s = REQ;
        end else if (skid_empty_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (halt || halt_pend_r) begin
          // The outstanding fetch is younger than the HALT: its data is dropped.
          if (ack_s) begin
            state_nxt_s     = HALTED;
            squash_nxt_s    = 1'b0;
            halt_pend_nxt_s = 1'b0;
          end else begin
            squash_nxt_s    = 1'b1;
            halt_pend_nxt_s = 1'b1;
          end
        end else if (redirect_valid) begin
          flush_s      = 1'b1;
          pc_nxt_s     = redirect_pc & 16'hFFFE;
          squash_nxt_s = ~ack_s;
        end else if (ack_s) begin
          if (squash_r) begin
            squash_nxt_s = 1'b0;
          end else begin
            accept_s    = 1'b1;
            pc_nxt_s    = inc16(pc_r);
            state_nxt_s = (slot_free_s && skid_empty_s) ? REQ : IDLE;
          end
        end else begin
          state_nxt_s = REQ;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    hold_addr_s = (state_r == REQ) && !ack_s;
  end

  // Architectural PC, FSM state and the held fetch address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      squash_r    <= 1'b0;
      halt_pend_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      squash_r    <= squash_nxt_s;
      halt_pend_r <= halt_pend_nxt_s;
      if (hold_addr_s) addr_r <= addr_r;
      else             addr_r <= pc_nxt_s;
    end
  end

  fetch_skid1 u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .in_valid  (accept_s),
    .in_data   (entry_s),
    .in_ready  (skid_empty_s),
    .slot_free (slot_free_s),
    .out_ready (if_ready),
    .out_valid (if_valid),
    .out_data  (out_entry_s)
  );

  assign imem.imem_req  = (state_r == REQ);
  assign imem.imem_addr = addr_r;
  assign halted         = (state_r == HALTED);
  assign if_instr       = out_entry_s.instr;
  assign if_pc          = out_entry_s.pc;
  assign if_pc_plus2    = out_entry_s.pc_plus2;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus a randomized run, checked
// against a program-order model of the PC stream seen by decode.
module tb_fetch_pc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, halt, if_ready, if_valid, halted;
  logic [15:0] redirect_pc, if_instr, if_pc, if_pc_plus2;
  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_PC(16'h0000), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .if_ready(if_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .halted(halted)
  );

  // Second instance near the top of the address space, zero-wait memory.
  logic        w_rst_n, w_if_valid, w_halted;
  logic [15:0] w_if_instr, w_if_pc, w_if_pc_plus2;
  fetch_pc_ctrl_if wbus ();
  assign wbus.imem_rdata = wbus.imem_addr ^ 16'hA5A5;

  fetch_pc_ctrl #(.RESET_PC(16'hFFFC), .WIDTH(16)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem(wbus),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .halt(1'b0),
    .if_ready(1'b1), .if_valid(w_if_valid), .if_instr(w_if_instr),
    .if_pc(w_if_pc), .if_pc_plus2(w_if_pc_plus2), .halted(w_halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] exp_pc, stop_pc, last_del_pc, prev_addr;
  bit          sb_on, halt_seen, stop_valid, spurious, prev_req, prev_ack;
  int          cyc, last_del, del_gap, n_del, mem_cnt, mem_lat, lat_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: memory response and scoreboard at negedge, then the edge.
  task automatic step();
    logic        eff_redirect;
    logic [15:0] nxt;
    @(negedge clk);
    if (bus.imem_req === 1'b1) begin
      if (mem_cnt == 0) mem_lat = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
      if (mem_cnt >= mem_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;
        mem_cnt        = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        mem_cnt++;
      end
    end else begin
      bus.imem_ack   = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.imem_rdata = 16'($urandom);
      mem_cnt        = 0;
    end
    eff_redirect = redirect_valid && !halt && !halt_seen;
    if (sb_on) begin
      check_eq("addr_bit0", {31'd0, bus.imem_addr[0]}, 32'd0);
      if (prev_req && !prev_ack) begin
        check_eq("req_held", {31'd0, bus.imem_req}, 32'd1);
        check_eq("addr_held", {16'd0, bus.imem_addr}, {16'd0, prev_addr});
      end
      if (if_valid && if_ready && !eff_redirect) begin
        nxt = exp_pc + 16'h0002;
        check_eq("if_pc", {16'd0, if_pc}, {16'd0, exp_pc});
        check_eq("if_instr", {16'd0, if_instr}, {16'd0, exp_pc ^ 16'hA5A5});
        check_eq("if_pc_plus2", {16'd0, if_pc_plus2}, {16'd0, nxt});
        if (halt_seen && stop_valid) check_eq("post_halt_pc", {31'd0, exp_pc == stop_pc}, 32'd0);
        last_del_pc = exp_pc;
        exp_pc      = nxt;
        del_gap     = cyc - last_del;
        last_del    = cyc;
        n_del++;
      end
      if (eff_redirect) exp_pc = redirect_pc & 16'hFFFE;
      if (halt && !halt_seen) begin
        halt_seen  = 1'b1;
        stop_valid = bus.imem_req;
        stop_pc    = bus.imem_addr;
      end
    end
    prev_req  = sb_on && (bus.imem_req === 1'b1);
    prev_ack  = bus.imem_ack;
    prev_addr = bus.imem_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int lat, input bit rdy);
    rst_n = 1'b0;
    sb_on = 1'b0;
    if_ready = rdy;
    lat_mode = lat;
    repeat (3) step();
    rst_n = 1'b1;
    exp_pc = 16'h0000; halt_seen = 1'b0; stop_valid = 1'b0;
    prev_req = 1'b0; mem_cnt = 0; n_del = 0; last_del = cyc; del_gap = 0;
    sb_on = 1'b1;
  endtask

  logic [15:0] wpc [3];
  logic [15:0] wp2 [3];
  logic [15:0] wins[3];
  int          k, cnt;

  initial begin
    rst_n = 1'b0; w_rst_n = 1'b0; wbus.imem_ack = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; if_ready = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    spurious = 1'b0; lat_mode = 0; mem_cnt = 0; mem_lat = 0; cyc = 0; sb_on = 1'b0;
    exp_pc = 16'h0000; stop_pc = 16'h0000; last_del_pc = 16'h0000; prev_addr = 16'h0000;
    halt_seen = 1'b0; stop_valid = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    last_del = 0; del_gap = 0; n_del = 0;

    // Reset values, then first request in the second cycle after release
    repeat (3) step();
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, if_instr}, 32'd0);
    check_eq("rst_pc", {16'd0, if_pc}, 32'd0);
    check_eq("rst_pc2", {16'd0, if_pc_plus2}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1; sb_on = 1'b1;
    check_eq("first_cycle_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    // Zero-wait back-to-back fetch with continuous delivery
    for (int i = 0; i < 8; i++) begin
      check_eq("tput_req", {31'd0, bus.imem_req}, 32'd1);
      check_eq("tput_addr", {16'd0, bus.imem_addr}, 32'(2 * i));
      if (i > 0) check_eq("tput_valid", {31'd0, if_valid}, 32'd1);
      step();
    end

    // Three-cycle memory latency: one instruction every four cycles
    do_reset(3, 1'b1);
    repeat (30) step();
    check_eq("lat3_gap", 32'(del_gap), 32'd4);
    check_eq("lat3_count_ok", {31'd0, n_del >= 5}, 32'd1);

    // Decode stalls: output then skid fill, fetch stops, resumes in order
    do_reset(0, 1'b0);
    step(); step(); step();
    check_eq("stall_req_off", {31'd0, bus.imem_req}, 32'd0);
    check_eq("stall_out_pc", {16'd0, if_pc}, 32'h0000);
    repeat (2) step();
    check_eq("stall_req_still_off", {31'd0, bus.imem_req}, 32'd0);
    if_ready = 1'b1;
    for (int i = 0; i < 10 && bus.imem_req !== 1'b1; i++) step();
    check_eq("resume_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("resume_addr", {16'd0, bus.imem_addr}, 32'h0004);
    check_eq("resume_delivered", 32'(n_del), 32'd2);

    // Redirect while the fetch of 0008 is still waiting for its ack
    do_reset(3, 1'b1);
    for (int i = 0; i < 60 && !(bus.imem_req === 1'b1 && bus.imem_addr == 16'h0008 && mem_cnt == 0); i++) step();
    check_eq("redir_setup_addr", {16'd0, bus.imem_addr}, 32'h0008);
    redirect_valid = 1'b1; redirect_pc = 16'h1235;
    step();
    check_eq("redir_addr_kept", {16'd0, bus.imem_addr}, 32'h0008);
    for (int i = 0; i < 10 && bus.imem_addr == 16'h0008; i++) step();
    check_eq("redir_new_addr", {16'd0, bus.imem_addr}, 32'h1234);
    cnt = n_del;
    for (int i = 0; i < 20 && n_del == cnt; i++) step();
    check_eq("redir_first_pc", {16'd0, last_del_pc}, 32'h1234);

    // Halt together with a redirect while a fetch is outstanding
    do_reset(3, 1'b1);
    for (int i = 0; i < 60 && !(bus.imem_req === 1'b1 && bus.imem_addr == 16'h0006 && mem_cnt == 0); i++) step();
    check_eq("halt_setup_addr", {16'd0, bus.imem_addr}, 32'h0006);
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    for (int i = 0; i < 10 && halted !== 1'b1; i++) step();
    check_eq("halted", {31'd0, halted}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req !== 1'b0) cnt++;
      redirect_valid = (i == 5);
      step();
    end
    check_eq("halt_req_quiet", 32'(cnt), 32'd0);
    check_eq("halt_sticky", {31'd0, halted}, 32'd1);

    // Randomized: latency 0..3, stalls, redirects, stray acks while idle
    do_reset(-1, 1'b1);
    spurious = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom);
      end
      step();
    end
    check_eq("rand_progress", {31'd0, n_del >= 50}, 32'd1);
    spurious = 1'b0; sb_on = 1'b0; rst_n = 1'b0;

    // PC wrap on the second instance, then reset in the middle of a request
    for (int i = 0; i < 3; i++) begin wpc[i] = 16'hDEAD; wp2[i] = 16'hDEAD; wins[i] = 16'hDEAD; end
    w_rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (w_if_valid === 1'b1 && k < 3) begin
        wpc[k] = w_if_pc; wp2[k] = w_if_pc_plus2; wins[k] = w_if_instr; k++;
      end
    end
    check_eq("wrap_pc0", {16'd0, wpc[0]}, 32'hFFFC);
    check_eq("wrap_pc1", {16'd0, wpc[1]}, 32'hFFFE);
    check_eq("wrap_pc2", {16'd0, wpc[2]}, 32'h0000);
    check_eq("wrap_pc2_of_fffe", {16'd0, wp2[1]}, 32'h0000);
    check_eq("wrap_instr2", {16'd0, wins[2]}, 32'hA5A5);
    check_eq("wrap_req_active", {31'd0, wbus.imem_req}, 32'd1);
    w_rst_n = 1'b0;
    step();
    check_eq("wrst_req", {31'd0, wbus.imem_req}, 32'd0);
    check_eq("wrst_addr", {16'd0, wbus.imem_addr}, 32'hFFFC);
    check_eq("wrst_valid", {31'd0, w_if_valid}, 32'd0);
    check_eq("wrst_instr", {16'd0, w_if_instr}, 32'd0);
    check_eq("wrst_pc", {16'd0, w_if_pc}, 32'd0);
    check_eq("wrst_pc2", {16'd0, w_if_pc_plus2}, 32'd0);
    check_eq("wrst_halted", {31'd0, w_halted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Instruction-fetch front end that owns the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Delivers {instr, pc, pc+2} to decode over a valid/ready handshake, with a one-entry skid buffer.
- Handles branch/jump redirects, including squashing an in-flight fetch, and HALT.
- Sits between the instruction memory and the IF/ID boundary. It consumes the +2 next-PC arithmetic.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- WIDTH, 16, data and address width; only 16 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request. Once raised, held high with imem_addr stable until imem_ack.
- imem_addr  out  16  fetch address; bit0 is always 0.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle. Only meaningful while imem_req=1.
- imem_rdata  in  16  fetched instruction.
- redirect_valid  in  1  one-cycle pulse from execute: taken branch or jump.
- redirect_pc  in  16  redirect target; bit0 is ignored and forced to 0.
- halt  in  1  one-cycle pulse from decode on a HALT instruction.
- if_ready  in  1  decode can accept this cycle.
- if_valid  out  1  output slot holds an instruction.
- if_instr  out  16  instruction.
- if_pc  out  16  address of if_instr.
- if_pc_plus2  out  16  if_pc + 2, modulo 2^16.
- halted  out  1  high once in HALTED.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - pc=RESET_PC and state=IDLE.
  - squash=0 and skid empty.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus2=0, halted=0.
- Reset overrides everything, including an outstanding request. The memory is also reset on the same reset.
- States:
  - IDLE: imem_req=0.
  - REQ: imem_req=1, imem_addr=pc.
  - HALTED: imem_req=0, halted=1.
- State and pc are registered; imem_req and imem_addr decode from registered state only.
- IDLE->REQ when the skid is empty and no halt is pending. First imem_req=1 occurs in the 2nd cycle after rst_n rises.
- REQ, no ack: stay in REQ; imem_addr must not change.
- REQ, ack, no squash, no redirect:
  - The captured entry is {imem_rdata, pc, pc+2}, then pc<=pc+2.
  - If the output slot is empty or consumed (if_valid&if_ready) this cycle, the entry goes to the output. A nonempty skid moves to the output first and the new entry then goes to the skid.
  - If the output slot is full and not consumed, the entry goes to the skid.
  - Next state is REQ if the skid is empty after the edge (back-to-back, throughput 1 instr/cycle with zero-wait memory); otherwise IDLE.
- Output ordering is strictly program order. The skid drains to the output on the first cycle the output is empty or consumed.
- Redirect (redirect_valid=1):
  - Clear if_valid and skid at the edge; pc<=redirect_pc&16'hFFFE.
  - In REQ without ack the same cycle: set squash, stay in REQ, keep the old imem_addr.
  - On a later ack with squash=1: discard imem_rdata, clear squash, stay in REQ with imem_addr=new pc next cycle.
  - Redirect in the same cycle as an ack: discard the data, then REQ the new pc next cycle.
  - Redirect in IDLE: go to REQ next cycle.
  - A second redirect while squash=1 overwrites the target pc.
- Halt (halt=1):
  - If no request is outstanding, go to HALTED.
  - If a request is outstanding, set squash and a halt_pend flag. On ack, discard the data and go to HALTED.
  - if_valid and skid are not cleared: the HALT instruction and older entries already delivered stay valid and drain normally.
- halt and redirect in the same cycle: halt wins and the redirect is ignored.
- HALTED is left only by reset; redirect_valid is ignored there.
- pc wraps 16'hFFFE -> 16'h0000; if_pc_plus2 wraps likewise, with no flag.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum {IDLE, REQ, HALTED}.
  - PC_STEP=16'h0002.
  - INSTR_W=16.
  - skid-entry struct {instr, pc, pc_plus2}.
- Sub-module: fetch_skid1, the one-entry skid/output register pair with flush, valid/ready in and out.
- The +2 adder uses the project's standard 16-bit incrementer; no new adder.

Test Plan:
- Reset release, imem_ack tied 1, imem_rdata=addr^16'hA5A5, if_ready=1 -> imem_addr 0000,0002,0004... on consecutive cycles; if_valid continuous; if_pc_plus2=if_pc+2.
- Ack with 3-cycle latency -> imem_addr held stable for 3 cycles; one instruction delivered per 4 cycles; no duplicates or drops.
- if_ready=0 for 5 cycles, ack tied 1 -> first entry goes to output, second to skid, then imem_req=0. On ready: outputs 0000 then 0002, then fetch resumes at 0004.
- Redirect to 16'h1235 while a 3-cycle-latency fetch of 0008 is pending -> imem_addr stays 0008 until ack; data discarded; next imem_addr=1234; first if_pc after redirect=1234.
- halt the same cycle as a redirect to 0100, request outstanding -> ack data discarded; halted=1; imem_req stays 0 for 20 cycles.
- pc preset near wrap, RESET_PC=16'hFFFC -> if_pc FFFC, FFFE, 0000; if_pc_plus2 for FFFE = 0000. Assert rst_n=0 mid-request -> all outputs equal the reset values next cycle.
